// File: rtl/decoder_scan_sequencer.sv
// -----------------------------------------------------------------------------
// decoder_scan_sequencer
//
// Purpose:
//   Drives the select (A, B) and active-low enable inputs of a 2-to-4 decoder.
//   Scans channels 0..3 in order ({A,B} = channel index, A = MSB). Each
//   channel is preceded by a fixed blanking gap (enable=1) and then held
//   active (enable=0) for a programmable dwell time. Runs continuously or
//   as a single pass.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a scan (sampled only while idle)
//   stop      in   abort the scan (sampled in every state, highest priority)
//   one_shot  in   latched with start: 1 = single pass, 0 = loop forever
//   dwell     in   latched with start: active cycles per channel (0 acts as 1)
//   A, B      out  decoder select, registered
//   enable    out  decoder enable, active-low, registered
//   busy      out  1 while blanking or dwelling
//   done      out  one-cycle pulse when a single pass completes normally
// -----------------------------------------------------------------------------
module decoder_scan_sequencer #(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               one_shot,
  input  logic [DWELL_W-1:0] dwell,
  output logic               A,
  output logic               B,
  output logic               enable,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DWELL = 2'd2
  } state_t;

  localparam logic [3:0]         BLANK_LAST = 4'(BLANK_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  state_t             state;
  logic [3:0]         blank_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_lat;
  logic               one_shot_lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      A            <= 1'b0;
      B            <= 1'b0;
      enable       <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      blank_cnt    <= '0;
      dwell_cnt    <= '0;
      dwell_lat    <= '0;
      one_shot_lat <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        // Abort: disable the decoder, keep the select lines where they are.
        state     <= IDLE;
        enable    <= 1'b1;
        busy      <= 1'b0;
        blank_cnt <= '0;
        dwell_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            enable <= 1'b1;
            busy   <= 1'b0;
            if (start) begin
              dwell_lat    <= (dwell == '0) ? DWELL_ONE : dwell;
              one_shot_lat <= one_shot;
              {A, B}       <= 2'b00;
              blank_cnt    <= '0;
              state        <= BLANK;
              busy         <= 1'b1;
            end
          end

          BLANK: begin
            if (blank_cnt == BLANK_LAST) begin
              state     <= DWELL;
              enable    <= 1'b0;
              blank_cnt <= '0;
              dwell_cnt <= '0;
            end else begin
              blank_cnt <= blank_cnt + 4'd1;
            end
          end

          DWELL: begin
            if (dwell_cnt == dwell_lat - DWELL_ONE) begin
              dwell_cnt <= '0;
              // Select lines only move on the edge that also raises enable,
              // so the decoder never sees a channel change while enabled.
              enable    <= 1'b1;
              if (({A, B} == 2'b11) && one_shot_lat) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                {A, B} <= {A, B} + 2'b01;   // 11 wraps to 00 in loop mode
                state  <= BLANK;
              end
            end else begin
              dwell_cnt <= dwell_cnt + DWELL_ONE;
            end
          end

          default: begin
            state  <= IDLE;
            enable <= 1'b1;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan_sequencer
//
// Directed bench for decoder_scan_sequencer with default parameters
// (DWELL_W=8, BLANK_CYCLES=2). Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_decoder_scan_sequencer;

  localparam int BLK = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       one_shot;
  logic [7:0] dwell;
  logic       A;
  logic       B;
  logic       enable;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  decoder_scan_sequencer #(
    .DWELL_W      (8),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .one_shot (one_shot),
    .dwell    (dwell),
    .A        (A),
    .B        (B),
    .enable   (enable),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Select lines may only change on a sample where enable is high.
  logic [1:0] prev_ab = 2'b00;
  always @(negedge clk) begin
    if (rst_n && ({A, B} != prev_ab))
      check_val("ab_change_while_enabled", {31'd0, enable}, 32'd1);
    prev_ab = {A, B};
  end

  // Starts a scan at the current falling edge, then checks ncyc samples.
  // Sample t is taken just after edge k+t (k = edge that accepts start).
  // With disturb set, a start with different settings is pulsed mid-scan.
  task automatic run_scan(input logic os, input int dw, input int ncyc, input bit disturb);
    int p;
    logic [1:0] eab;
    logic een, ebusy, edone;
    p = BLK + ((dw == 0) ? 1 : dw);
    start    = 1'b1;
    one_shot = os;
    dwell    = 8'(dw);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      if (os && (t >= 4 * p)) begin
        eab = 2'b11; een = 1'b1; ebusy = 1'b0; edone = (t == 4 * p);
      end else begin
        eab = 2'((t / p) % 4); een = ((t % p) < BLK); ebusy = 1'b1; edone = 1'b0;
      end
      check_val("ab",     {30'd0, A, B},     {30'd0, eab});
      check_val("enable", {31'd0, enable},   {31'd0, een});
      check_val("busy",   {31'd0, busy},     {31'd0, ebusy});
      check_val("done",   {31'd0, done},     {31'd0, edone});
      if (disturb && t == 7) begin
        start = 1'b1; dwell = 8'd9; one_shot = ~os;
      end else begin
        start = 1'b0;
      end
      if (t < ncyc - 1) @(negedge clk);
    end
    start = 1'b0;
    $display("scan one_shot=%0d dwell=%0d cycles=%0d disturb=%0d checked, failures so far %0d",
             os, dw, ncyc, disturb, n_fail);
  endtask

  task automatic check_idle(input string tag, input logic [1:0] eab);
    check_val({tag, "_ab"},     {30'd0, A, B},   {30'd0, eab});
    check_val({tag, "_enable"}, {31'd0, enable}, 32'd1);
    check_val({tag, "_busy"},   {31'd0, busy},   32'd0);
    check_val({tag, "_done"},   {31'd0, done},   32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; one_shot = 1'b0; dwell = 8'd0;
    repeat (3) @(negedge clk);
    check_idle("reset", 2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset", 2'b00);
    $display("reset state checked");

    // One-shot, dwell=3: period 5, done at sample 20.
    run_scan(1'b1, 3, 23, 1'b0);
    @(negedge clk);

    // dwell=0 behaves like dwell=1: period 3.
    run_scan(1'b1, 0, 15, 1'b0);
    @(negedge clk);

    // Loop mode, dwell=1: wraps 11 -> 00 and never signals done.
    run_scan(1'b0, 1, 30, 1'b0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_idle("loop_stop", 2'b01);   // sample 30: 30/3=10, 10%4=2 -> stop after sample 29 (ch 01)
    @(negedge clk);

    // Stop during the dwell of channel 2 (sample 12 of period 5).
    run_scan(1'b0, 3, 13, 1'b0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_idle("stop_ch2", 2'b10);
    repeat (3) @(negedge clk);
    check_idle("stop_hold", 2'b10);
    $display("stop during channel 2 dwell checked");

    // start and stop together while idle: remains idle.
    start = 1'b1; stop = 1'b1; one_shot = 1'b1; dwell = 8'd2;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check_idle("start_stop", 2'b10);
    @(negedge clk);
    check_idle("start_stop_after", 2'b10);
    $display("start with stop in idle checked");

    // Start pulse and new settings while busy must not disturb the pass.
    run_scan(1'b1, 3, 23, 1'b1);
    @(negedge clk);

    // Asynchronous reset in the middle of channel 1 dwell.
    run_scan(1'b0, 5, 11, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset", 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_async_reset", 2'b00);
    $display("asynchronous reset mid-dwell checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
